// File: rtl/panda_risc_v_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU on 33-bit sign-extended operands, one request in flight.
// Latency: 35 cycles from acceptance to result valid (1 cycle on divide by zero).
// Backpressure: result held in OUT until m_div_ready; s_div_ready only in IDLE, no path from m_div_ready.
module panda_risc_v_divider #(
  parameter int inst_id_width = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [32:0]              s_div_op_a,
  input  logic [32:0]              s_div_op_b,
  input  logic                     s_div_rem_sel,
  input  logic [4:0]               s_div_rd_id,
  input  logic [inst_id_width-1:0] s_div_inst_id,
  input  logic                     s_div_valid,
  output logic                     s_div_ready,
  output logic [31:0]              m_div_res,
  output logic [4:0]               m_div_rd_id,
  output logic [inst_id_width-1:0] m_div_inst_id,
  output logic                     m_div_valid,
  input  logic                     m_div_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [5:0]  cnt;
  logic [32:0] dvd;
  logic [32:0] dvs;
  logic [31:0] quo;
  logic [33:0] rem;
  logic        sign_q;
  logic        sign_r;
  logic        rem_sel;

  logic        b_zero;
  logic [32:0] a_abs;
  logic [32:0] b_abs;
  logic [33:0] rem_sh;
  logic [33:0] rem_sub;
  logic [33:0] rem_nxt;
  logic        q_bit;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic        unused_rem_msb;

  assign b_zero = (s_div_op_b == 33'd0);
  assign a_abs  = s_div_op_a[32] ? (33'd0 - s_div_op_a) : s_div_op_a;
  assign b_abs  = s_div_op_b[32] ? (33'd0 - s_div_op_b) : s_div_op_b;

  // Partial remainder never exceeds the divisor, so bit 33 only matters in the shifted compare.
  assign rem_sh  = {rem[32:0], dvd[32]};
  assign q_bit   = (rem_sh >= {1'b0, dvs});
  assign rem_sub = rem_sh - {1'b0, dvs};
  assign rem_nxt = q_bit ? rem_sub : rem_sh;

  // Low 32 bits of the negated 33-bit values equal the negation of their low 32 bits.
  assign quo_fix = sign_q ? (32'd0 - quo) : quo;
  assign rem_fix = sign_r ? (32'd0 - rem[31:0]) : rem[31:0];

  assign unused_rem_msb = rem[33];

  always_comb begin
    state_nxt   = state;
    s_div_ready = 1'b0;
    m_div_valid = 1'b0;
    case (state)
      IDLE: begin
        s_div_ready = 1'b1;
        if (s_div_valid) begin
          state_nxt = b_zero ? OUT : CALC;
        end
      end
      CALC: begin
        if (cnt == 6'd32) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        state_nxt = OUT;
      end
      OUT: begin
        m_div_valid = 1'b1;
        if (m_div_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 6'd0;
      dvd           <= '0;
      dvs           <= '0;
      quo           <= '0;
      rem           <= '0;
      sign_q        <= 1'b0;
      sign_r        <= 1'b0;
      rem_sel       <= 1'b0;
      m_div_res     <= '0;
      m_div_rd_id   <= '0;
      m_div_inst_id <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (s_div_valid) begin
            m_div_rd_id   <= s_div_rd_id;
            m_div_inst_id <= s_div_inst_id;
            rem_sel       <= s_div_rem_sel;
            dvd           <= a_abs;
            dvs           <= b_abs;
            quo           <= '0;
            rem           <= '0;
            cnt           <= 6'd0;
            sign_q        <= s_div_op_a[32] ^ s_div_op_b[32];
            sign_r        <= s_div_op_a[32];
            if (b_zero) begin
              m_div_res <= s_div_rem_sel ? s_div_op_a[31:0] : 32'hFFFF_FFFF;
            end
          end
        end
        CALC: begin
          dvd <= {dvd[31:0], 1'b0};
          quo <= {quo[30:0], q_bit};
          rem <= rem_nxt;
          cnt <= (cnt == 6'd32) ? 6'd0 : cnt + 6'd1;
        end
        FIX: begin
          m_div_res <= rem_sel ? rem_fix : quo_fix;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_panda_risc_v_divider.sv
// Scoreboard bench for panda_risc_v_divider: directed cases plus random DIV/DIVU/REM/REMU traffic.
module tb_panda_risc_v_divider;

  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [32:0]   s_div_op_a;
  logic [32:0]   s_div_op_b;
  logic          s_div_rem_sel;
  logic [4:0]    s_div_rd_id;
  logic [IW-1:0] s_div_inst_id;
  logic          s_div_valid;
  logic          s_div_ready;
  logic [31:0]   m_div_res;
  logic [4:0]    m_div_rd_id;
  logic [IW-1:0] m_div_inst_id;
  logic          m_div_valid;
  logic          m_div_ready;

  panda_risc_v_divider #(.inst_id_width(IW)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_div_op_a    (s_div_op_a),
    .s_div_op_b    (s_div_op_b),
    .s_div_rem_sel (s_div_rem_sel),
    .s_div_rd_id   (s_div_rd_id),
    .s_div_inst_id (s_div_inst_id),
    .s_div_valid   (s_div_valid),
    .s_div_ready   (s_div_ready),
    .m_div_res     (m_div_res),
    .m_div_rd_id   (m_div_rd_id),
    .m_div_inst_id (m_div_inst_id),
    .m_div_valid   (m_div_valid),
    .m_div_ready   (m_div_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   res;
    logic [4:0]    rd;
    logic [IW-1:0] id;
    int            acc;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic rdy_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Reference: RISC-V division semantics on the sign-extended 33-bit operands.
  function automatic logic [31:0] ref_div(input logic [32:0] a, input logic [32:0] b, input logic rs);
    longint sa;
    longint sbv;
    logic [63:0] q;
    logic [63:0] r;
    sa  = {{31{a[32]}}, a};
    sbv = {{31{b[32]}}, b};
    if (sbv == 0) return rs ? a[31:0] : 32'hFFFF_FFFF;
    q = sa / sbv;
    r = sa % sbv;
    return rs ? r[31:0] : q[31:0];
  endfunction

  task automatic push_exp(input logic [31:0] expv, input logic [4:0] rd, input logic [IW-1:0] id,
                          input logic [32:0] b);
    exp_t e;
    e.res = expv;
    e.rd  = rd;
    e.id  = id;
    e.acc = cyc + 1;
    e.lat = (b == 33'd0) ? 0 : 34;
    sb.push_back(e);
  endtask

  task automatic send(input logic [32:0] a, input logic [32:0] b, input logic rs,
                      input logic [4:0] rd, input logic [IW-1:0] id, input logic [31:0] expv);
    int n;
    @(posedge clk);
    #1;
    s_div_op_a    = a;
    s_div_op_b    = b;
    s_div_rem_sel = rs;
    s_div_rd_id   = rd;
    s_div_inst_id = id;
    s_div_valid   = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_div_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!s_div_ready) begin
      fail_now("accept");
    end else begin
      push_exp(expv, rd, id, b);
    end
    @(posedge clk);
    #1;
    s_div_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || m_div_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) fail_now("drain");
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_rand) m_div_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: latency on first valid, stability under backpressure, payload on handshake.
  logic          prev_vld  = 1'b0;
  logic          prev_hold = 1'b0;
  logic [31:0]   h_res;
  logic [4:0]    h_rd;
  logic [IW-1:0] h_id;
  exp_t          got;

  always @(negedge clk) begin
    if (rst) begin
      prev_vld  = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (m_div_valid && !prev_vld) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got res %h with empty scoreboard", m_div_res);
        end else begin
          chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
        end
      end
      if (m_div_valid && prev_hold) begin
        chk("hold_res", m_div_res, h_res);
        chk("hold_rd", 32'(m_div_rd_id), 32'(h_rd));
        chk("hold_id", 32'(m_div_inst_id), 32'(h_id));
      end
      if (m_div_valid && m_div_ready && sb.size() != 0) begin
        got = sb.pop_front();
        chk("res", m_div_res, got.res);
        chk("rd_id", 32'(m_div_rd_id), 32'(got.rd));
        chk("inst_id", 32'(m_div_inst_id), 32'(got.id));
      end
      prev_vld  = m_div_valid;
      prev_hold = m_div_valid && !m_div_ready;
      h_res     = m_div_res;
      h_rd      = m_div_rd_id;
      h_id      = m_div_inst_id;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x;
    logic [31:0] y;
    logic [32:0] a;
    logic [32:0] b;
    logic        rs;
    logic [4:0]  rd;
    logic [IW-1:0] id;
    int          n;

    rst           = 1'b1;
    s_div_op_a    = '0;
    s_div_op_b    = '0;
    s_div_rem_sel = 1'b0;
    s_div_rd_id   = '0;
    s_div_inst_id = '0;
    s_div_valid   = 1'b0;
    m_div_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_s_ready", 32'(s_div_ready), 32'd1);
    chk("rst_m_valid", 32'(m_div_valid), 32'd0);
    chk("rst_res", m_div_res, 32'd0);
    chk("rst_rd", 32'(m_div_rd_id), 32'd0);
    chk("rst_id", 32'(m_div_inst_id), 32'd0);

    rdy_rand = 1'b1;
    send(33'h1_FFFF_FFF9, 33'h0_0000_0002, 1'b0, 5'd5, 4'd3, 32'hFFFF_FFFD);
    send(33'h1_FFFF_FFF9, 33'h0_0000_0002, 1'b1, 5'd5, 4'd3, 32'hFFFF_FFFF);
    send(33'h0_FFFF_FFFF, 33'h0_0000_0002, 1'b0, 5'd1, 4'd4, 32'h7FFF_FFFF);
    send(33'h0_FFFF_FFFF, 33'h0_0000_0002, 1'b1, 5'd2, 4'd5, 32'h0000_0001);
    send(33'h1_8000_0000, 33'h1_FFFF_FFFF, 1'b0, 5'd7, 4'd6, 32'h8000_0000);
    send(33'h1_8000_0000, 33'h1_FFFF_FFFF, 1'b1, 5'd8, 4'd7, 32'h0000_0000);
    send(33'h0_0000_0064, 33'h0_0000_0000, 1'b0, 5'd9, 4'd8, 32'hFFFF_FFFF);
    send(33'h0_0000_0064, 33'h0_0000_0000, 1'b1, 5'd10, 4'd9, 32'h0000_0064);
    drain();

    // Backpressure: result held for 10 cycles while a second request waits.
    rdy_rand = 1'b0;
    @(posedge clk);
    #1 m_div_ready = 1'b0;
    send(33'h1_FFFF_FFF9, 33'h0_0000_0002, 1'b0, 5'd5, 4'd3, 32'hFFFF_FFFD);
    n = 0;
    @(negedge clk);
    while (!m_div_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!m_div_valid) fail_now("bp_valid_wait");
    s_div_op_a    = 33'd100;
    s_div_op_b    = 33'd7;
    s_div_rem_sel = 1'b0;
    s_div_rd_id   = 5'd12;
    s_div_inst_id = 4'd11;
    s_div_valid   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_s_ready", 32'(s_div_ready), 32'd0);
      chk("bp_m_valid", 32'(m_div_valid), 32'd1);
    end
    @(posedge clk);
    #1 m_div_ready = 1'b1;
    @(negedge clk);
    chk("bp_s_ready_before_hs", 32'(s_div_ready), 32'd0);
    @(negedge clk);
    chk("bp_s_ready_after_hs", 32'(s_div_ready), 32'd1);
    chk("bp_m_valid_after_hs", 32'(m_div_valid), 32'd0);
    push_exp(32'h0000_000E, 5'd12, 4'd11, 33'd7);
    @(posedge clk);
    #1 s_div_valid = 1'b0;
    drain();

    // Reset during iteration 15 of a division, then a fresh request.
    rdy_rand = 1'b1;
    send(33'd12345, 33'd3, 1'b0, 5'd3, 4'd2, 32'd4115);
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_m_valid", 32'(m_div_valid), 32'd0);
    chk("midrst_s_ready", 32'(s_div_ready), 32'd1);
    send(33'd100, 33'd7, 1'b0, 5'd4, 4'd1, 32'h0000_000E);
    drain();

    for (int i = 0; i < 48; i++) begin
      x = $urandom();
      y = $urandom();
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'hFFFF_FFFF;
        2: x = 32'h8000_0000;
        3: y = $urandom_range(1, 9);
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) begin
        a = {x[31], x};
        b = {y[31], y};
      end else begin
        a = {1'b0, x};
        b = {1'b0, y};
      end
      rs = 1'($urandom_range(0, 1));
      rd = 5'($urandom_range(0, 31));
      id = IW'($urandom_range(0, 15));
      send(a, b, rs, rd, id, ref_div(a, b, rs));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/panda_risc_v_divider.md
# panda_risc_v_divider

Iterative radix-2 divider execution unit of the Panda RISC-V core. It sits directly downstream of the dispatcher's divider execution-request port. It accepts one DIV/DIVU/REM/REMU request at a time, as 33-bit sign-extended operands plus RD index and instruction ID. It returns a 32-bit quotient or remainder, with RD index and instruction ID, on a registered valid/ready result port toward write-back.

## Interface
- inst_id_width, 4, instruction ID width
- clk  input  1  clock
- rst  input  1  reset; one clock; reset is synchronous and active-high
- s_div_op_a  input  33  dividend, sign-extended (bit 32 = sign for signed ops, 0 for unsigned)
- s_div_op_b  input  33  divisor, same encoding
- s_div_rem_sel  input  1  0 -> quotient, 1 -> remainder
- s_div_rd_id  input  5  RD index
- s_div_inst_id  input  inst_id_width  instruction ID
- s_div_valid  input  1  request valid
- s_div_ready  output  1  request ready
- m_div_res  output  32  result
- m_div_rd_id  output  5  RD index of result
- m_div_inst_id  output  inst_id_width  instruction ID of result
- m_div_valid  output  1  result valid
- m_div_ready  input  1  result ready

## Operation
- Operands are treated as 33-bit two's-complement. Signedness is carried entirely by the extension; the unit has no signed/unsigned flag.
- States:
  - IDLE: s_div_ready=1. On s_div_valid, latch all request fields.
    - If op_b==0, go to OUT.
    - Otherwise latch |op_a| and |op_b| as 33-bit unsigned values, sign_q = a[32]^b[32], sign_r = a[32]; go to CALC.
  - CALC: restoring division, one quotient bit per cycle, MSB first, over 33 iterations.
    - 6-bit counter runs 0..32; the 34-bit partial remainder uses shift-subtract-restore.
    - At count 32, go to FIX.
  - FIX: negate the quotient if sign_q; negate the remainder if sign_r. Select the low 32 bits by rem_sel into the result register; go to OUT.
  - OUT: m_div_valid=1. On m_div_ready, go to IDLE.
- Divide by zero: result is 32'hFFFF_FFFF for the quotient, op_a[31:0] for the remainder. The CALC/FIX path is bypassed.
- Signed overflow (−2^31 / −1) needs no special case. The 33-bit quotient +2^31 truncates to 32'h8000_0000 and the remainder is 0, which is RISC-V compliant.
- Requests are never dropped. Exactly one result is produced per accepted request, in order. Only one request can be in flight.

## Timing
- Reset values: state=IDLE, s_div_ready=1, m_div_valid=0, m_div_res=0, m_div_rd_id=0, m_div_inst_id=0, counter=0.
- s_div_ready is high only in IDLE. It is registered-state based, with no combinational path from m_div_ready.
- Normal latency: request accepted at edge E. CALC runs edges E+1..E+33 and FIX is at E+34. m_div_valid is high after E+34, i.e. 35 cycles from acceptance to first valid cycle.
- Divide by zero: m_div_valid is high after edge E, i.e. 1 cycle latency.
- While m_div_valid=1 and m_div_ready=0, m_div_res, m_div_rd_id and m_div_inst_id are held stable.
- An output handshake at edge F returns the unit to IDLE. The earliest next acceptance is at edge F+1 (s_div_ready high during the cycle after F). There is no same-cycle turnaround.
- rst asserted in any state, including mid-CALC or OUT: at the next edge the unit returns to reset values and the in-flight operation is discarded.
- s_div_valid while not IDLE is ignored; the request is not latched.

## Test plan
- DIV: op_a=33'h1_FFFF_FFF9 (−7), op_b=33'h0_0000_0002, rem_sel=0, rd_id=5, inst_id=3 -> m_div_res=32'hFFFF_FFFD, rd_id=5, inst_id=3, valid 35 cycles after acceptance. Same request with rem_sel=1 -> 32'hFFFF_FFFF.
- DIVU/REMU: op_a=33'h0_FFFF_FFFF, op_b=33'h0_0000_0002 -> quotient 32'h7FFF_FFFF, remainder 32'h0000_0001.
- Overflow: op_a=33'h1_8000_0000, op_b=33'h1_FFFF_FFFF -> quotient 32'h8000_0000, remainder 32'h0000_0000.
- Divide by zero: op_a=33'h0_0000_0064, op_b=0 -> quotient 32'hFFFF_FFFF, remainder 32'h0000_0064, valid 1 cycle after acceptance.
- Backpressure: hold m_div_ready=0 for 10 cycles in OUT -> outputs stable, s_div_ready=0, and a second s_div_valid is not accepted. Release -> handshake, then s_div_ready=1 one cycle later and the second request is accepted.
- Reset mid-CALC: assert rst at iteration 15 -> next cycle m_div_valid=0, s_div_ready=1. A new request 100/7 then returns 32'h0000_000E.
